neg_unit_seq: RTL and testbench
===============================

// Module: neg_unit_seq
// PURPOSE
//  Parametrised multi-cycle negation unit for the Basys3 ALU datapath.
//  Modes: one's complement, two's complement, absolute value, pass-through.
//  Processes CHUNK bits per cycle with a rippled carry, which keeps LUT/carry cost low at large WIDTH.
//  Valid/ready handshake on input and output; raises overflow and zero flags.
// PARAMETERS
//  WIDTH     16  operand/result width in bits (>=2)
//  CHUNK      4  bits processed per RUN cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  SATURATE   0  1: two's-complement/ABS of MIN returns MAX (0x7FFF) instead of wrapping to MIN
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand/mode present
//  in_ready   out  1      unit idle and able to accept
//  in_data    in   WIDTH  operand, signed two's complement
//  in_mode    in   2      00 ONES, 01 TWOS, 10 ABS, 11 PASS
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  result
//  out_ovf    out  1      TWOS/ABS applied to MIN (1 followed by zeros)
//  out_zero   out  1      out_data == 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, any state, including mid-RUN): FSM->IDLE; in_ready=0; out_valid=0; out_data=0;
//   out_ovf=0; out_zero=0; operand discarded. in_ready=1 from the first clock edge after release.
//  All outputs are registered.
//  FSM IDLE -> RUN -> DONE -> IDLE; NCH = WIDTH/CHUNK.
//  IDLE: in_ready=1. Accept on in_valid&in_ready (cycle T): latch in_data into shift reg, latch mode;
//   inv   = ONES | TWOS | (ABS & in_data[MSB]);  carry = TWOS | (ABS & in_data[MSB]);
//   ovf   = (TWOS|ABS) & (in_data == MIN). Chunk counter := 0. in_ready drops next cycle.
//  RUN: each cycle: r = (op[CHUNK-1:0] ^ {CHUNK{inv}}) + carry; shift r into result from MSB side;
//   shift op right by CHUNK; carry := carry-out of r; counter++. After NCH cycles -> DONE.
//  PASS: inv=0, carry=0 (result == operand, ovf=0).
//  DONE: out_valid=1 in cycle T+NCH+1. If ovf & SATURATE, out_data = MAX, else the wrapped result
//   (MIN for -MIN). out_zero computed on final out_data.
//  out_data/flags stay stable while out_valid & ~out_ready (no limit on stall length).
//  On out_valid & out_ready: out_valid=0 next cycle, FSM -> IDLE, in_ready=1 next cycle.
//  Throughput: one operation per NCH+2 cycles; no overlap of accept and output.
//  in_data/in_mode changes after accept are ignored. in_valid while busy is not accepted (in_ready=0).
//  CHUNK==WIDTH: single RUN cycle; out_valid in cycle T+2.
//  Final carry-out is discarded; width is WIDTH throughout, no sign extension.
// STRUCTURE
//  Shared package/header neg_pkg: mode localparams (MODE_ONES/TWOS/ABS/PASS), FSM state encodings,
//   MIN/MAX constant functions of WIDTH.
//  Sub-module neg_chunk (combinational, CHUNK-bit): inputs op, inv, cin; outputs sum, cout.
//  Top-level: FSM, chunk counter ($clog2(NCH+1) bits), operand and result shift registers, flags.
// TESTING (WIDTH=16, CHUNK=4, SATURATE=0 unless stated)
//  1 TWOS 0x0005 accepted at T -> out_valid at T+5, out_data 0xFFFB, ovf=0, zero=0.
//  2 ONES 0x00FF -> 0xFF00; PASS 0x1234 -> 0x1234, ovf=0.
//  3 TWOS 0x8000 -> 0x8000 ovf=1; SATURATE=1: TWOS/ABS 0x8000 -> 0x7FFF ovf=1.
//  4 ABS 0xFFFB -> 0x0005; ABS 0x0007 -> 0x0007; TWOS 0x0000 -> 0x0000 zero=1.
//  5 out_ready=0 for 3 cycles in DONE -> out_data and flags held, in_ready=0;
//    out_ready=1 -> out_valid=0 and in_ready=1 next cycle; in_valid held high while busy is ignored.
//  6 rst_n low during 2nd RUN cycle -> out_valid=0, in_ready=0 immediately (async);
//    after release TWOS 0x0001 -> 0xFFFF. CHUNK=16 variant: out_valid at T+2.

Source files
------------

// File: rtl/neg_pkg.sv
// Shared definitions for the sequential negation unit: mode codes, FSM states and
// width-dependent MIN/MAX constants.
package neg_pkg;

   localparam logic [1:0] MODE_ONES = 2'b00;
   localparam logic [1:0] MODE_TWOS = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;
   localparam logic [1:0] MODE_PASS = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam int unsigned MAX_WIDTH = 64;

   // Most negative signed value of the given width, zero-extended to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] min_val(input int unsigned width);
      return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_val(input int unsigned width);
      return min_val(width) - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/neg_chunk.sv
// One CHUNK-bit slice of the rippled negation: optional inversion plus carry-in.
module neg_chunk #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] op,
   input  logic             inv,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   always_comb begin
      {cout, sum} = {1'b0, op ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};
   end

endmodule

// File: rtl/neg_unit_seq.sv
// Multi-cycle ONES/TWOS/ABS/PASS unit: processes CHUNK bits per cycle, LSB first,
// with a registered carry between chunks and a valid/ready handshake on both sides.
module neg_unit_seq
   import neg_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHUNK    = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned NCH = WIDTH / CHUNK;
   localparam int unsigned CW  = $clog2(NCH + 1);
   localparam logic [WIDTH-1:0] MIN = WIDTH'(min_val(WIDTH));
   localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

   if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("neg_unit_seq: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] op_q;
   logic [WIDTH-1:0] res_q;
   logic             inv_q;
   logic             carry_q;
   logic             ovf_q;

   logic             accept;
   logic             neg_abs;
   logic             acc_inv;
   logic             acc_carry;
   logic             acc_ovf;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_cout;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] final_data;
   logic             last_chunk;

   always_comb begin
      accept    = in_valid && in_ready;
      neg_abs   = (in_mode == MODE_ABS) && in_data[WIDTH-1];
      acc_inv   = (in_mode == MODE_ONES) || (in_mode == MODE_TWOS) || neg_abs;
      acc_carry = (in_mode == MODE_TWOS) || neg_abs;
      acc_ovf   = ((in_mode == MODE_TWOS) || (in_mode == MODE_ABS)) && (in_data == MIN);
   end

   neg_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .op   (op_q[CHUNK-1:0]),
      .inv  (inv_q),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   // New chunk enters the result from the MSB side; after NCH cycles it is aligned.
   always_comb begin
      res_next   = (res_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
      final_data = (ovf_q && SATURATE) ? MAX : res_next;
      last_chunk = (cnt_q == CW'(NCH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         res_q     <= '0;
         inv_q     <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q     <= in_data;
                  inv_q    <= acc_inv;
                  carry_q  <= acc_carry;
                  ovf_q    <= acc_ovf;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= StRun;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            StRun: begin
               op_q    <= op_q >> CHUNK;
               res_q   <= res_next;
               carry_q <= chunk_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (last_chunk) begin
                  out_valid <= 1'b1;
                  out_data  <= final_data;
                  out_ovf   <= ovf_q;
                  out_zero  <= (final_data == '0);
                  state_q   <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_neg_unit_seq.sv
// Scoreboard bench: three instances (CHUNK=4, CHUNK=4 saturating, CHUNK=16) share stimulus.
module tb_neg_unit_seq;

   localparam logic [1:0] ONES = 2'b00;
   localparam logic [1:0] TWOS = 2'b01;
   localparam logic [1:0] ABS  = 2'b10;
   localparam logic [1:0] PASS = 2'b11;

   typedef struct {
      logic [15:0] data;
      logic        ovf;
      logic        zero;
      int          t_acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_ready;
   logic        in_ready_w  [3];
   logic        out_valid_w [3];
   logic [15:0] out_data_w  [3];
   logic        out_ovf_w   [3];
   logic        out_zero_w  [3];

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   exp_t sb_q [3][$];
   bit   seen [3];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      neg_unit_seq #(
         .WIDTH    (16),
         .CHUNK    ((g == 2) ? 16 : 4),
         .SATURATE (g == 1)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[g]),
         .in_data   (in_data),
         .in_mode   (in_mode),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .out_data  (out_data_w[g]),
         .out_ovf   (out_ovf_w[g]),
         .out_zero  (out_zero_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int lat(input int i);
      return (i == 2) ? 2 : 5;
   endfunction

   function automatic void model(input logic [1:0] mode, input logic [15:0] d, input bit sat,
                                 output exp_t e);
      logic [15:0] r;
      case (mode)
         ONES:    r = ~d;
         TWOS:    r = 16'd0 - d;
         ABS:     r = d[15] ? 16'd0 - d : d;
         default: r = d;
      endcase
      e.ovf = ((mode == TWOS) || (mode == ABS)) && (d == 16'h8000);
      if (e.ovf && sat) r = 16'h7FFF;
      e.data  = r;
      e.zero  = (r == 16'h0000);
      e.t_acc = 0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (out_valid_w[i]) begin
               check($sformatf("d%0d_sb_pending", i), sb_q[i].size() != 0, 1);
               if (sb_q[i].size() != 0) begin
                  mon_e = sb_q[i][0];
                  if (!seen[i]) begin
                     check($sformatf("d%0d_latency", i), cyc - mon_e.t_acc, lat(i));
                     seen[i] = 1'b1;
                  end
                  if (out_ready) begin
                     check($sformatf("d%0d_data", i), out_data_w[i], mon_e.data);
                     check($sformatf("d%0d_ovf", i), out_ovf_w[i], mon_e.ovf);
                     check($sformatf("d%0d_zero", i), out_zero_w[i], mon_e.zero);
                     void'(sb_q[i].pop_front());
                     seen[i] = 1'b0;
                  end
               end
            end
         end
      end
   end

   function automatic bit all_ready();
      return in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
   endfunction

   // Called at a falling edge; returns at the falling edge of cycle T+1.
   task automatic do_op(input logic [1:0] mode, input logic [15:0] d);
      int   n = 0;
      exp_t e;
      while (!all_ready() && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", all_ready(), 1);
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = d;
      for (int i = 0; i < 3; i++) begin
         model(mode, d, (i == 1), e);
         e.t_acc = cyc;
         sb_q[i].push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb_q[0].size() + sb_q[1].size() + sb_q[2].size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  t_mode [8];
      logic [15:0] t_data [8];
      int          n;
      t_mode = '{TWOS, ONES, PASS, TWOS, ABS, ABS, TWOS, ABS};
      t_data = '{16'h0005, 16'h00FF, 16'h1234, 16'h8000, 16'hFFFB, 16'h0007, 16'h0000, 16'h8000};

      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_in_ready", in_ready_w[i], 0);
         check("rst_out_valid", out_valid_w[i], 0);
         check("rst_out_data", out_data_w[i], 0);
         check("rst_ovf", out_ovf_w[i], 0);
         check("rst_zero", out_zero_w[i], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", all_ready(), 1);

      for (int k = 0; k < 8; k++) do_op(t_mode[k], t_data[k]);
      drain();

      // Output stall with in_valid held high while busy.
      out_ready = 1'b0;
      do_op(ONES, 16'h00FF);
      n = 0;
      while (!out_valid_w[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid", out_valid_w[0], 1);
      in_valid = 1'b1;
      in_mode  = TWOS;
      in_data  = 16'hAAAA;
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check("stall_hold_valid", out_valid_w[i], 1);
            check("stall_hold_data", out_data_w[i], 16'hFF00);
            check("stall_hold_ovf", out_ovf_w[i], 0);
            check("stall_in_ready", in_ready_w[i], 0);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("post_hs_valid", out_valid_w[i], 0);
         check("post_hs_ready", in_ready_w[i], 1);
      end
      drain();

      // Asynchronous reset during the second RUN cycle.
      do_op(TWOS, 16'h0001);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("async_rst_valid", out_valid_w[i], 0);
         check("async_rst_ready", in_ready_w[i], 0);
         sb_q[i].delete();
         seen[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst2", all_ready(), 1);
      do_op(TWOS, 16'h0001);
      drain();

      for (int k = 0; k < 8; k++) do_op(2'($urandom_range(0, 3)), 16'($urandom));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
